// File: rtl/mips_multicycle_controller.sv
// Purpose : multi-cycle control FSM for the shared-ALU, single-memory-port MIPS datapath.
// Latency : zero-wait R/I-type 4 cycles, lw 5, sw 4, beq/bne/j/jal 3; +1 cycle per memReady stall.
// Backpressure: FETCH/MEMRD/MEMWR hold their outputs until memReady; abort to FETCH after MEM_WAIT_MAX stalls.
//
// Ports: clk/rst (async active-low); opCode/functionCode from IR; zeroFlag from ALU; memReady from memory.
//        Datapath selects (IorD, pcSrc, ALUSrcA/B, ALUOperation, regDst, memToReg) and enables
//        (memRead, memWrite, IRWrite, pcWrite, regWrite); status pulses instrDone/busErr/illegalOp;
//        instrCount = retired instructions (wraps).
module mips_multicycle_controller #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opCode,
    input  logic [5:0]       functionCode,
    input  logic             zeroFlag,
    input  logic             memReady,
    output logic             IorD,
    output logic             memRead,
    output logic             memWrite,
    output logic             IRWrite,
    output logic             pcWrite,
    output logic [1:0]       pcSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUOperation,
    output logic             regWrite,
    output logic [1:0]       regDst,
    output logic [1:0]       memToReg,
    output logic             instrDone,
    output logic             busErr,
    output logic             illegalOp,
    output logic [CNT_W-1:0] instrCount
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, RWB, EXEC_I, IWB,
        MEMADDR, MEMRD, MEMWB, MEMWR, BRANCH, JUMP, JAL
    } state_t;

    state_t     state, next_state;
    logic [7:0] waitCnt;
    logic       timeout;
    logic       stall;
    logic       r_legal;
    logic [2:0] r_aluop;

    // R-type funct decode; shared by DECODE (legality) and EXEC_R (ALU op).
    always_comb begin
        r_legal = 1'b1;
        r_aluop = ALU_ADD;
        case (functionCode)
            6'b100000: r_aluop = ALU_ADD;
            6'b100010: r_aluop = ALU_SUB;
            6'b100100: r_aluop = ALU_AND;
            6'b100101: r_aluop = ALU_OR;
            6'b101010: r_aluop = ALU_SLT;
            default:   r_legal = 1'b0;
        endcase
    end

    // Only the three memory-facing states ever wait; memReady on the limit cycle still wins.
    assign timeout = (state == FETCH || state == MEMRD || state == MEMWR) &&
                     !memReady && (waitCnt == WAIT_MAX);
    assign stall   = (state == FETCH || state == MEMRD || state == MEMWR) &&
                     !memReady && !timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FETCH;
            waitCnt    <= '0;
            instrCount <= '0;
        end else begin
            state      <= next_state;
            // Any exit, including the abort back into FETCH, restarts the wait budget.
            waitCnt    <= stall ? waitCnt + 8'd1 : 8'd0;
            if (instrDone) begin
                instrCount <= instrCount + CNT_W'(1);
            end
        end
    end

    always_comb begin
        next_state   = state;
        IorD         = 1'b0;
        memRead      = 1'b0;
        memWrite     = 1'b0;
        IRWrite      = 1'b0;
        pcWrite      = 1'b0;
        pcSrc        = 2'b00;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ALUOperation = ALU_ADD;
        regWrite     = 1'b0;
        regDst       = 2'b00;
        memToReg     = 2'b00;
        instrDone    = 1'b0;
        busErr       = 1'b0;
        illegalOp    = 1'b0;

        case (state)
            FETCH: begin
                memRead = 1'b1;
                ALUSrcB = 2'b01;            // PC + 4
                if (memReady) begin
                    IRWrite    = 1'b1;
                    pcWrite    = 1'b1;
                    next_state = DECODE;
                end else if (timeout) begin
                    busErr     = 1'b1;      // PC untouched, refetch same address
                    next_state = FETCH;
                end
            end
            DECODE: begin
                ALUSrcB = 2'b11;            // speculative branch target into ALUOut
                case (opCode)
                    OP_RTYPE: begin
                        if (r_legal) begin
                            next_state = EXEC_R;
                        end else begin
                            illegalOp  = 1'b1;
                            next_state = FETCH;
                        end
                    end
                    OP_ADDI, OP_ANDI: next_state = EXEC_I;
                    OP_LW, OP_SW:     next_state = MEMADDR;
                    OP_BEQ, OP_BNE:   next_state = BRANCH;
                    OP_J:             next_state = JUMP;
                    OP_JAL:           next_state = JAL;
                    default: begin
                        illegalOp  = 1'b1;
                        next_state = FETCH;
                    end
                endcase
            end
            EXEC_R: begin
                ALUSrcA      = 1'b1;
                ALUOperation = r_aluop;
                next_state   = RWB;
            end
            RWB: begin
                regWrite   = 1'b1;
                regDst     = 2'b01;
                instrDone  = 1'b1;
                next_state = FETCH;
            end
            EXEC_I: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                ALUOperation = (opCode == OP_ANDI) ? ALU_AND : ALU_ADD;
                next_state   = IWB;
            end
            IWB: begin
                regWrite   = 1'b1;
                instrDone  = 1'b1;
                next_state = FETCH;
            end
            MEMADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = (opCode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                memRead = 1'b1;
                IorD    = 1'b1;
                if (memReady) begin
                    next_state = MEMWB;
                end else if (timeout) begin
                    busErr     = 1'b1;
                    next_state = FETCH;
                end
            end
            MEMWB: begin
                regWrite   = 1'b1;
                memToReg   = 2'b01;
                instrDone  = 1'b1;
                next_state = FETCH;
            end
            MEMWR: begin
                memWrite = 1'b1;
                IorD     = 1'b1;
                if (memReady) begin
                    instrDone  = 1'b1;
                    next_state = FETCH;
                end else if (timeout) begin
                    busErr     = 1'b1;
                    next_state = FETCH;
                end
            end
            BRANCH: begin
                ALUSrcA      = 1'b1;
                ALUOperation = ALU_SUB;
                pcSrc        = 2'b01;
                // opCode[0] distinguishes bne (000101) from beq (000100).
                pcWrite      = opCode[0] ? !zeroFlag : zeroFlag;
                instrDone    = 1'b1;
                next_state   = FETCH;
            end
            JUMP: begin
                pcWrite    = 1'b1;
                pcSrc      = 2'b10;
                instrDone  = 1'b1;
                next_state = FETCH;
            end
            JAL: begin
                // PC already holds PC+4 from FETCH, so it is the link value written to $31.
                regWrite   = 1'b1;
                regDst     = 2'b10;
                memToReg   = 2'b10;
                pcWrite    = 1'b1;
                pcSrc      = 2'b10;
                instrDone  = 1'b1;
                next_state = FETCH;
            end
            default: next_state = FETCH;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Purpose : directed self-checking bench for mips_multicycle_controller.
// Latency : expectations are per cycle, hand-derived for each instruction class.
// Backpressure: memReady stalls and timeouts are driven explicitly per cycle.
module tb_mips_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opCode, functionCode;
    logic        zeroFlag, memReady;
    logic        IorD, memRead, memWrite, IRWrite, pcWrite, ALUSrcA, regWrite;
    logic [1:0]  pcSrc, ALUSrcB, regDst, memToReg;
    logic [2:0]  ALUOperation;
    logic        instrDone, busErr, illegalOp;
    logic [31:0] instrCount;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_count = '0;

    always #5 clk = ~clk;

    mips_multicycle_controller #(.MEM_WAIT_MAX(15), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opCode(opCode), .functionCode(functionCode),
        .zeroFlag(zeroFlag), .memReady(memReady), .IorD(IorD), .memRead(memRead),
        .memWrite(memWrite), .IRWrite(IRWrite), .pcWrite(pcWrite), .pcSrc(pcSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOperation(ALUOperation),
        .regWrite(regWrite), .regDst(regDst), .memToReg(memToReg),
        .instrDone(instrDone), .busErr(busErr), .illegalOp(illegalOp),
        .instrCount(instrCount)
    );

    // Field order: IorD memRead memWrite IRWrite pcWrite pcSrc ALUSrcA ALUSrcB ALUOp
    //              regWrite regDst memToReg instrDone busErr illegalOp
    logic [20:0] obs;
    assign obs = {IorD, memRead, memWrite, IRWrite, pcWrite, pcSrc, ALUSrcA, ALUSrcB,
                  ALUOperation, regWrite, regDst, memToReg, instrDone, busErr, illegalOp};

    function automatic logic [20:0] cv(input logic iord, input logic mr, input logic mw,
                                       input logic irw, input logic pcw, input logic [1:0] pcs,
                                       input logic asa, input logic [1:0] asb, input logic [2:0] op,
                                       input logic rw, input logic [1:0] rd, input logic [1:0] m2r,
                                       input logic done, input logic be, input logic ill);
        return {iord, mr, mw, irw, pcw, pcs, asa, asb, op, rw, rd, m2r, done, be, ill};
    endfunction

    function automatic logic [20:0] e_fetch(input logic rdy, input logic be);
        return cv(1'b0, 1'b1, 1'b0, rdy, rdy, 2'b00, 1'b0, 2'b01, 3'b010, 1'b0, 2'b00, 2'b00, 1'b0, be, 1'b0);
    endfunction

    function automatic logic [20:0] e_decode(input logic ill);
        return cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 3'b010, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, ill);
    endfunction

    task automatic drive(input logic rdy, input logic z);
        memReady = rdy;
        zeroFlag = z;
        #2;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; memReady = 1'b0; zeroFlag = 1'b0; opCode = '0; functionCode = '0;
        #3;
        checks++;
        if (obs !== e_fetch(1'b0, 1'b0)) begin
            errors++; $display("FAIL reset_outputs: got %b expected %b", obs, e_fetch(1'b0, 1'b0));
        end
        checks++;
        if (instrCount !== 32'd0) begin
            errors++; $display("FAIL reset_count: got %0d expected 0", instrCount);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_r_type;
        logic [5:0]  fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [2:0]  op [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        logic [20:0] ex [4];
        for (int i = 0; i < 5; i++) begin
            opCode = 6'b000000; functionCode = fn[i];
            ex[0] = e_fetch(1'b1, 1'b0);
            ex[1] = e_decode(1'b0);
            ex[2] = cv(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, op[i], 0, 2'b00, 2'b00, 0, 0, 0);
            ex[3] = cv(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b010, 1, 2'b01, 2'b00, 1, 0, 0);
            for (int c = 0; c < 4; c++) begin
                drive(1'b1, 1'b0);
                checks++;
                if (obs !== ex[c]) begin
                    errors++; $display("FAIL rtype_f%b_cyc%0d: got %b expected %b", fn[i], c, obs, ex[c]);
                end
                tick;
            end
            exp_count++;
            checks++;
            if (instrCount !== exp_count) begin
                errors++; $display("FAIL rtype_count: got %0d expected %0d", instrCount, exp_count);
            end
        end
    endtask

    task automatic test_i_type;
        logic [5:0]  opc [2] = '{6'b001000, 6'b001100};
        logic [2:0]  alu [2] = '{3'b010, 3'b000};
        logic [20:0] ex [4];
        for (int i = 0; i < 2; i++) begin
            opCode = opc[i];
            ex[0] = e_fetch(1'b1, 1'b0);
            ex[1] = e_decode(1'b0);
            ex[2] = cv(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, alu[i], 0, 2'b00, 2'b00, 0, 0, 0);
            ex[3] = cv(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b010, 1, 2'b00, 2'b00, 1, 0, 0);
            for (int c = 0; c < 4; c++) begin
                drive(1'b1, 1'b0);
                checks++;
                if (obs !== ex[c]) begin
                    errors++; $display("FAIL itype_op%b_cyc%0d: got %b expected %b", opc[i], c, obs, ex[c]);
                end
                tick;
            end
            exp_count++;
        end
        checks++;
        if (instrCount !== exp_count) begin
            errors++; $display("FAIL itype_count: got %0d expected %0d", instrCount, exp_count);
        end
    endtask

    // lw with three stalled MEMRD cycles: 8 cycles total.
    task automatic test_lw_wait;
        logic        rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [20:0] ex [8];
        logic [20:0] memrd;
        opCode = 6'b100011;
        memrd = cv(1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 2'b00, 2'b00, 0, 0, 0);
        ex[0] = e_fetch(1'b1, 1'b0);
        ex[1] = e_decode(1'b0);
        ex[2] = cv(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010, 0, 2'b00, 2'b00, 0, 0, 0);
        ex[3] = memrd; ex[4] = memrd; ex[5] = memrd; ex[6] = memrd;
        ex[7] = cv(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b010, 1, 2'b00, 2'b01, 1, 0, 0);
        for (int c = 0; c < 8; c++) begin
            drive(rdy[c], 1'b0);
            checks++;
            if (obs !== ex[c]) begin
                errors++; $display("FAIL lw_wait_cyc%0d: got %b expected %b", c, obs, ex[c]);
            end
            tick;
        end
        exp_count++;
        checks++;
        if (instrCount !== exp_count) begin
            errors++; $display("FAIL lw_count: got %0d expected %0d", instrCount, exp_count);
        end
    endtask

    // sw with one stalled MEMWR cycle; instrDone only on the ready cycle.
    task automatic test_sw;
        logic        rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [20:0] ex [5];
        opCode = 6'b101011;
        ex[0] = e_fetch(1'b1, 1'b0);
        ex[1] = e_decode(1'b0);
        ex[2] = cv(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010, 0, 2'b00, 2'b00, 0, 0, 0);
        ex[3] = cv(1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 2'b00, 2'b00, 0, 0, 0);
        ex[4] = cv(1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 2'b00, 2'b00, 1, 0, 0);
        for (int c = 0; c < 5; c++) begin
            drive(rdy[c], 1'b0);
            checks++;
            if (obs !== ex[c]) begin
                errors++; $display("FAIL sw_cyc%0d: got %b expected %b", c, obs, ex[c]);
            end
            tick;
        end
        exp_count++;
        checks++;
        if (instrCount !== exp_count) begin
            errors++; $display("FAIL sw_count: got %0d expected %0d", instrCount, exp_count);
        end
    endtask

    task automatic test_branch;
        logic [5:0]  opc [4] = '{6'b000100, 6'b000101, 6'b000100, 6'b000101};
        logic        z   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic        tkn [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [20:0] ex [3];
        for (int i = 0; i < 4; i++) begin
            opCode = opc[i];
            ex[0] = e_fetch(1'b1, 1'b0);
            ex[1] = e_decode(1'b0);
            ex[2] = cv(0, 0, 0, 0, tkn[i], 2'b01, 1, 2'b00, 3'b110, 0, 2'b00, 2'b00, 1, 0, 0);
            for (int c = 0; c < 3; c++) begin
                drive(1'b1, z[i]);
                checks++;
                if (obs !== ex[c]) begin
                    errors++; $display("FAIL branch_op%b_z%0d_cyc%0d: got %b expected %b", opc[i], z[i], c, obs, ex[c]);
                end
                tick;
            end
            exp_count++;
        end
        checks++;
        if (instrCount !== exp_count) begin
            errors++; $display("FAIL branch_count: got %0d expected %0d", instrCount, exp_count);
        end
    endtask

    task automatic test_jump;
        logic [5:0]  opc [2] = '{6'b000010, 6'b000011};
        logic [20:0] ex [3];
        for (int i = 0; i < 2; i++) begin
            opCode = opc[i];
            ex[0] = e_fetch(1'b1, 1'b0);
            ex[1] = e_decode(1'b0);
            ex[2] = (i == 0) ? cv(0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 3'b010, 0, 2'b00, 2'b00, 1, 0, 0)
                             : cv(0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 3'b010, 1, 2'b10, 2'b10, 1, 0, 0);
            for (int c = 0; c < 3; c++) begin
                drive(1'b1, 1'b0);
                checks++;
                if (obs !== ex[c]) begin
                    errors++; $display("FAIL jump_op%b_cyc%0d: got %b expected %b", opc[i], c, obs, ex[c]);
                end
                tick;
            end
            exp_count++;
        end
        checks++;
        if (instrCount !== exp_count) begin
            errors++; $display("FAIL jump_count: got %0d expected %0d", instrCount, exp_count);
        end
    endtask

    // FETCH starved for 16 cycles aborts on cycle 16; then memReady on the limit cycle wins.
    task automatic test_bus_err;
        logic [20:0] e;
        for (int c = 1; c <= 16; c++) begin
            drive(1'b0, 1'b0);
            e = e_fetch(1'b0, c == 16);
            checks++;
            if (obs !== e) begin
                errors++; $display("FAIL buserr_stall_cyc%0d: got %b expected %b", c, obs, e);
            end
            tick;
        end
        checks++;
        if (instrCount !== exp_count) begin
            errors++; $display("FAIL buserr_count: got %0d expected %0d", instrCount, exp_count);
        end
        for (int c = 1; c <= 15; c++) begin
            drive(1'b0, 1'b0);
            checks++;
            if (obs !== e_fetch(1'b0, 1'b0)) begin
                errors++; $display("FAIL limit_stall_cyc%0d: got %b expected %b", c, obs, e_fetch(1'b0, 1'b0));
            end
            tick;
        end
        opCode = 6'b000010;
        drive(1'b1, 1'b0);
        checks++;
        if (obs !== e_fetch(1'b1, 1'b0)) begin
            errors++; $display("FAIL limit_ready_wins: got %b expected %b", obs, e_fetch(1'b1, 1'b0));
        end
        tick;
        drive(1'b1, 1'b0);
        checks++;
        if (obs !== e_decode(1'b0)) begin
            errors++; $display("FAIL limit_decode: got %b expected %b", obs, e_decode(1'b0));
        end
        tick;
        tick;   // JUMP
        exp_count++;
        checks++;
        if (instrCount !== exp_count) begin
            errors++; $display("FAIL limit_count: got %0d expected %0d", instrCount, exp_count);
        end
    endtask

    task automatic test_illegal;
        logic [5:0] opc [2] = '{6'b111111, 6'b000000};
        for (int i = 0; i < 2; i++) begin
            opCode = opc[i]; functionCode = 6'b000000;
            drive(1'b1, 1'b0);
            tick;
            drive(1'b1, 1'b0);
            checks++;
            if (obs !== e_decode(1'b1)) begin
                errors++; $display("FAIL illegal_op%b_decode: got %b expected %b", opc[i], obs, e_decode(1'b1));
            end
            tick;
            drive(1'b0, 1'b0);
            checks++;
            if (obs !== e_fetch(1'b0, 1'b0)) begin
                errors++; $display("FAIL illegal_op%b_refetch: got %b expected %b", opc[i], obs, e_fetch(1'b0, 1'b0));
            end
            tick;
        end
        checks++;
        if (instrCount !== exp_count) begin
            errors++; $display("FAIL illegal_count: got %0d expected %0d", instrCount, exp_count);
        end
    endtask

    task automatic test_reset_mid;
        opCode = 6'b101011;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0);
            tick;
        end
        drive(1'b0, 1'b0);
        checks++;
        if (memWrite !== 1'b1) begin
            errors++; $display("FAIL midrst_memwr_before: got %b expected 1", memWrite);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== e_fetch(1'b0, 1'b0)) begin
            errors++; $display("FAIL midrst_outputs: got %b expected %b", obs, e_fetch(1'b0, 1'b0));
        end
        exp_count = '0;
        checks++;
        if (instrCount !== exp_count) begin
            errors++; $display("FAIL midrst_count: got %0d expected 0", instrCount);
        end
        #2;
        rst = 1'b1;
        tick;
        opCode = 6'b000010;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0);
            tick;
        end
        exp_count++;
        checks++;
        if (instrCount !== exp_count) begin
            errors++; $display("FAIL midrst_restart_count: got %0d expected %0d", instrCount, exp_count);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_r_type;
        test_i_type;
        test_lw_wait;
        test_sw;
        test_branch;
        test_jump;
        test_bus_err;
        test_illegal;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
